div_unsigned_nbit: RTL and testbench

- Iterative unsigned restoring divider for SIZE-bit operands. Produces one quotient bit per clock.
- Sits underneath the signed divide wrapper in the ALU. The wrapper converts operands to magnitudes and fixes up signs.
- Start/ready/valid handshake. An error flag reports divide-by-zero.

---
 rtl/div_unsigned_nbit_pkg.sv | 23 ++
 rtl/div_unsigned_nbit_if.sv | 41 ++++
 rtl/div_unsigned_nbit_step.sv | 32 +++
 rtl/div_unsigned_nbit.sv | 110 +++++++++++
 tb/tb_div_unsigned_nbit.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_unsigned_nbit_pkg.sv
// Shared definitions for the unsigned iterative divider: FSM states and
// the iteration counter sizing used by every instance.
package div_unsigned_nbit_pkg;

    // Default operand width used by the ALU.
    localparam int unsigned DefaultSize = 32;

    // Divider sequencing states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } div_state_e;

    // The counter must be able to hold SIZE itself, not just SIZE-1.
    function automatic int unsigned cnt_width(input int unsigned size);
        return $clog2(size + 1);
    endfunction

    // Counter width for the default operand width.
    localparam int unsigned DefaultCntWidth = cnt_width(DefaultSize);

endpackage

// File: rtl/div_unsigned_nbit_if.sv
// Start/ready/valid handshake and operand/result bus of the unsigned divider.
// The requester (signed wrapper or bench) uses the master side, the divider
// uses the slave side.
interface div_unsigned_nbit_if
    import div_unsigned_nbit_pkg::*;
#(
    parameter int unsigned SIZE = DefaultSize
);

    logic            start;
    logic            ready;
    logic            valid;
    logic            error;
    logic [SIZE-1:0] dividend;
    logic [SIZE-1:0] divisor;
    logic [SIZE-1:0] quotient;
    logic [SIZE-1:0] remainder;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  ready,
        input  valid,
        input  error,
        input  quotient,
        input  remainder
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output ready,
        output valid,
        output error,
        output quotient,
        output remainder
    );

endinterface

// File: rtl/div_unsigned_nbit_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits and record the quotient bit.
module div_unsigned_nbit_step #(
    parameter int unsigned SIZE = 32
) (
    input  logic [SIZE-1:0] rem_in,
    input  logic [SIZE-1:0] quo_in,
    input  logic [SIZE-1:0] divisor,
    output logic [SIZE-1:0] rem_out,
    output logic [SIZE-1:0] quo_out
);

    // The shifted remainder needs SIZE+1 bits; after restoring it is always
    // below the divisor again, so the top bit of the result is always zero.
    logic [SIZE:0] shifted;
    logic [SIZE:0] trial;
    logic [SIZE:0] next_rem;
    logic          fits;
    logic          unused_rem_msb;

    // Trial subtraction and restore select.
    always_comb begin
        shifted        = {rem_in, quo_in[SIZE-1]};
        trial          = shifted - {1'b0, divisor};
        fits           = (shifted >= {1'b0, divisor});
        next_rem       = fits ? trial : shifted;
        rem_out        = next_rem[SIZE-1:0];
        quo_out        = {quo_in[SIZE-2:0], fits};
        unused_rem_msb = next_rem[SIZE];
    end

endmodule

// File: rtl/div_unsigned_nbit.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// The dividend is shifted through the quotient register, which ends up
// holding the quotient; a zero divisor short-circuits to DONE with error set.
module div_unsigned_nbit
    import div_unsigned_nbit_pkg::*;
#(
    parameter int unsigned SIZE = DefaultSize
) (
    input logic                clk,
    input logic                reset,
    div_unsigned_nbit_if.slave bus
);

    localparam int unsigned CntWidth = cnt_width(SIZE);

    div_state_e          state_q, state_d;
    logic [SIZE-1:0]     quo_q, quo_d;
    logic [SIZE-1:0]     rem_q, rem_d;
    logic [SIZE-1:0]     dsr_q, dsr_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                err_q, err_d;

    logic [SIZE-1:0]     step_quo;
    logic [SIZE-1:0]     step_rem;

    div_unsigned_nbit_step #(
        .SIZE (SIZE)
    ) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // Next-state and datapath control; starts are only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    dsr_d = bus.divisor;
                    cnt_d = '0;
                    err_d = 1'b0;
                    if (bus.divisor == '0) begin
                        // Divide-by-zero result convention: all-ones quotient,
                        // dividend passed through as the remainder.
                        quo_d   = '1;
                        rem_d   = bus.dividend;
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        quo_d   = bus.dividend;
                        rem_d   = '0;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                quo_d = step_quo;
                rem_d = step_rem;
                cnt_d = cnt_q + CntWidth'(1);
                if (cnt_q == CntWidth'(SIZE - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            quo_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Handshake flags decode straight from the state; results are registered.
    always_comb begin
        bus.ready     = (state_q == StIdle);
        bus.valid     = (state_q == StDone);
        bus.error     = err_q;
        bus.quotient  = quo_q;
        bus.remainder = rem_q;
    end

endmodule

// File: tb/tb_div_unsigned_nbit.sv
// Self-checking bench for div_unsigned_nbit (SIZE=32): directed cases plus
// randomized operands checked against a plain-arithmetic reference model.
module tb_div_unsigned_nbit;

    localparam int unsigned SIZE    = 32;
    localparam int          MaxWait = 200;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    div_unsigned_nbit_if #(.SIZE(SIZE)) bus ();

    div_unsigned_nbit #(
        .SIZE (SIZE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: integer division, zero divisor yields all ones / dividend.
    function automatic void model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                  output logic [SIZE-1:0] q, output logic [SIZE-1:0] r,
                                  output logic e);
        if (b == '0) begin
            q = '1;
            r = a;
            e = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            e = 1'b0;
        end
    endfunction

    // Cycle (counting from 1 right after the acceptance edge) in which valid shows.
    function automatic int exp_latency(input logic [SIZE-1:0] b);
        return (b == '0) ? 1 : int'(SIZE) + 1;
    endfunction

    // Issue one operation and return at the negedge of its valid cycle.
    task automatic do_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                         output int lat, output bit ok);
        int n;
        @(negedge clk);
        n = 0;
        while (bus.ready !== 1'b1 && n < MaxWait) begin
            @(negedge clk);
            n++;
        end
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (bus.valid !== 1'b1 && lat < MaxWait) begin
            @(negedge clk);
            lat++;
        end
        ok = (bus.valid === 1'b1);
    endtask

    task automatic test_reset();
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #1 reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.ready, bus.valid, bus.error} !== 3'b100) begin
            $display("FAIL reset_flags: got rdy/vld/err=%b expected 100",
                     {bus.ready, bus.valid, bus.error});
        end else n_pass++;
        n_checks++;
        if ({bus.quotient, bus.remainder} !== '0) begin
            $display("FAIL reset_results: got q=%0h r=%0h expected 0/0",
                     bus.quotient, bus.remainder);
        end else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.ready, bus.valid} !== 2'b10) begin
            $display("FAIL reset_release_idle: got rdy/vld=%b expected 10",
                     {bus.ready, bus.valid});
        end else n_pass++;
    endtask

    task automatic test_directed();
        bit [31:0] ta [8] = '{32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3,
                              32'd5, 32'd9, 32'd50, 32'd0};
        bit [31:0] tb [8] = '{32'd7, 32'd1, 32'hFFFF_FFFF, 32'd10,
                              32'd0, 32'd3, 32'd8, 32'd0};
        bit [31:0] tq [8] = '{32'd14, 32'hFFFF_FFFF, 32'd1, 32'd0,
                              32'hFFFF_FFFF, 32'd3, 32'd6, 32'hFFFF_FFFF};
        bit [31:0] tr [8] = '{32'd2, 32'd0, 32'd0, 32'd3, 32'd5, 32'd0, 32'd2, 32'd0};
        bit        te [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        int lat;
        bit ok;
        for (int i = 0; i < 8; i++) begin
            do_op(ta[i], tb[i], lat, ok);
            n_checks++;
            if (!ok || lat != exp_latency(tb[i])) begin
                $display("FAIL directed_latency[%0d]: got valid=%0b at cycle %0d expected cycle %0d",
                         i, ok, lat, exp_latency(tb[i]));
            end else n_pass++;
            n_checks++;
            if (bus.quotient !== tq[i] || bus.remainder !== tr[i] || bus.error !== te[i]) begin
                $display("FAIL directed_result[%0d] %0h/%0h: got q=%0h r=%0h e=%b expected q=%0h r=%0h e=%b",
                         i, ta[i], tb[i], bus.quotient, bus.remainder, bus.error,
                         tq[i], tr[i], te[i]);
            end else n_pass++;
            @(negedge clk);
            n_checks++;
            if ({bus.ready, bus.valid} !== 2'b10) begin
                $display("FAIL directed_after_valid[%0d]: got rdy/vld=%b expected 10",
                         i, {bus.ready, bus.valid});
            end else n_pass++;
        end
    endtask

    task automatic test_ignore_and_hold();
        int lat;
        @(negedge clk);
        n_checks++;
        if (bus.ready !== 1'b1) begin
            $display("FAIL ignore_idle_ready: got %b expected 1", bus.ready);
        end else n_pass++;
        bus.start    = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd3;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = '1;
        bus.divisor  = '0;
        lat = 1;
        while (bus.valid !== 1'b1 && lat < MaxWait) begin
            if (lat == 3) begin
                bus.start    = 1'b1;
                bus.dividend = $urandom;
                bus.divisor  = $urandom_range(1, 9);
            end else begin
                bus.start = 1'b0;
            end
            if (lat == 4) begin
                n_checks++;
                if ({bus.ready, bus.valid} !== 2'b00) begin
                    $display("FAIL busy_flags: got rdy/vld=%b expected 00",
                             {bus.ready, bus.valid});
                end else n_pass++;
            end
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (bus.valid !== 1'b1 || lat != int'(SIZE) + 1) begin
            $display("FAIL ignore_latency: got valid=%b at cycle %0d expected cycle %0d",
                     bus.valid, lat, SIZE + 1);
        end else n_pass++;
        n_checks++;
        if (bus.quotient !== 32'd333 || bus.remainder !== 32'd1 || bus.error !== 1'b0) begin
            $display("FAIL ignore_result: got q=%0d r=%0d e=%b expected q=333 r=1 e=0",
                     bus.quotient, bus.remainder, bus.error);
        end else n_pass++;
        // A start during DONE must not be taken.
        bus.start    = 1'b1;
        bus.dividend = 32'd77;
        bus.divisor  = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.ready !== 1'b1 || bus.valid !== 1'b0 || bus.quotient !== 32'd333 ||
                bus.remainder !== 32'd1 || bus.error !== 1'b0) begin
                $display("FAIL hold[%0d]: got rdy=%b vld=%b q=%0d r=%0d e=%b expected 1 0 333 1 0",
                         i, bus.ready, bus.valid, bus.quotient, bus.remainder, bus.error);
            end else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        bit ok;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.ready, bus.valid, bus.error} !== 3'b100 ||
            {bus.quotient, bus.remainder} !== '0) begin
            $display("FAIL reset_mid_busy: got rdy/vld/err=%b q=%0h r=%0h expected 100 0 0",
                     {bus.ready, bus.valid, bus.error}, bus.quotient, bus.remainder);
        end else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        do_op(32'd50, 32'd8, lat, ok);
        n_checks++;
        if (!ok || lat != int'(SIZE) + 1 || bus.quotient !== 32'd6 ||
            bus.remainder !== 32'd2 || bus.error !== 1'b0) begin
            $display("FAIL after_reset_op: got valid=%b lat=%0d q=%0d r=%0d e=%b expected 1 %0d 6 2 0",
                     ok, lat, bus.quotient, bus.remainder, bus.error, SIZE + 1);
        end else n_pass++;
    endtask

    task automatic test_random();
        logic [SIZE-1:0] a, b, q, r;
        logic e;
        int lat;
        bit ok;
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom_range(1, 15);
                1: b = $urandom;
                2: b = $urandom >> $urandom_range(0, 31);
                default: b = (i % 5 == 0) ? '0 : a >> $urandom_range(0, 4);
            endcase
            model(a, b, q, r, e);
            do_op(a, b, lat, ok);
            n_checks++;
            if (!ok || lat != exp_latency(b) || bus.quotient !== q ||
                bus.remainder !== r || bus.error !== e) begin
                $display("FAIL random[%0d] %0h/%0h: got vld=%b lat=%0d q=%0h r=%0h e=%b expected lat=%0d q=%0h r=%0h e=%b",
                         i, a, b, ok, lat, bus.quotient, bus.remainder, bus.error,
                         exp_latency(b), q, r, e);
            end else n_pass++;
        end
        @(negedge clk);
    endtask

    // start held high: an operation is taken exactly in each idle cycle.
    task automatic test_back_to_back();
        logic [SIZE-1:0] pend_a, pend_b, q, r;
        logic e;
        int idle_at, valid_at, n_ops;
        bit exp_valid;
        @(negedge clk);
        idle_at  = 0;
        valid_at = -1;
        n_ops    = 0;
        pend_a   = '0;
        pend_b   = '0;
        for (int c = 0; c < 3000; c++) begin
            exp_valid = (c == valid_at);
            n_checks++;
            if (bus.valid !== exp_valid || bus.ready !== (c == idle_at)) begin
                $display("FAIL b2b_flags cycle %0d: got vld=%b rdy=%b expected vld=%b rdy=%b",
                         c, bus.valid, bus.ready, exp_valid, (c == idle_at));
            end else n_pass++;
            if (exp_valid) begin
                model(pend_a, pend_b, q, r, e);
                n_ops++;
                n_checks++;
                if (bus.quotient !== q || bus.remainder !== r || bus.error !== e) begin
                    $display("FAIL b2b_result op %0d %0h/%0h: got q=%0h r=%0h e=%b expected q=%0h r=%0h e=%b",
                             n_ops, pend_a, pend_b, bus.quotient, bus.remainder, bus.error,
                             q, r, e);
                end else n_pass++;
                if (n_ops == 12) break;
            end
            bus.start    = 1'b1;
            bus.dividend = $urandom;
            bus.divisor  = ($urandom_range(0, 5) == 0) ? '0 : $urandom >> $urandom_range(0, 28);
            if (c == idle_at) begin
                pend_a   = bus.dividend;
                pend_b   = bus.divisor;
                valid_at = c + exp_latency(pend_b);
                idle_at  = valid_at + 1;
            end
            @(negedge clk);
        end
        n_checks++;
        if (n_ops != 12) begin
            $display("FAIL b2b_op_count: got %0d operations expected 12", n_ops);
        end else n_pass++;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_and_hold();
        test_reset_mid_busy();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed",
                 n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
